axi_llc_sram_ecc_ctrl: RTL

Parametrised single-port SRAM front-end for the LLC data and tag arrays. It adds per-granule SECDED protection with partial-write read-modify-write (RMW) and a configurable read pipeline. Read data is held until the next read returns. An optional background scrubber walks the array and writes back corrected words. It sits between the LLC read/write units and one physical `tc_sram` macro of width `NumBanks*(G+K)`.

---
 rtl/axi_llc_sram_ecc_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_llc_sram_ecc_ctrl.sv
// axi_llc_sram_ecc_ctrl: SECDED-protected single-port SRAM front-end for the LLC
// arrays. Each word holds NumBanks granules of G data bits plus K check bits.
// Partial-granule writes use read-modify-write. Read latency is set by Latency.
// Define AXI_LLC_SRAM_SCRUB_EN to build the background scrubber.
module axi_llc_sram_ecc_ctrl #(
  parameter int unsigned NumWords      = 1024,
  parameter int unsigned DataWidth     = 128,
  parameter int unsigned ByteWidth     = 8,
  parameter int unsigned NumBanks      = 4,
  parameter int unsigned Latency       = 1,
  parameter int unsigned ScrubInterval = 256,
  localparam int unsigned AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth      = DataWidth / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic [NumBanks-1:0]  single_error_o,
  output logic [NumBanks-1:0]  multi_error_o,
  output logic                 scrub_fix_o,
  output logic                 scrub_uncorr_o
);

  localparam int unsigned G    = DataWidth / NumBanks;
  localparam int unsigned K    = $clog2(G) + 2;
  localparam int unsigned CW   = G + K;
  localparam int unsigned MemW = NumBanks * CW;
  localparam int unsigned BeG  = G / ByteWidth;

  if ((Latency < 1) || (Latency > 4) || (ScrubInterval < 2) || ((G % ByteWidth) != 0)) begin : g_param_check
    $error("axi_llc_sram_ecc_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, RMW_WAIT, SCRUB_WAIT} state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_USER, TAG_RMW, TAG_SCRUB} tag_e;
  typedef enum logic [1:0] {WR_USER, WR_RMW, WR_SCRUB} wr_src_e;

  // Codeword layout: index 0 is overall parity, indices 1..CW-1 are Hamming
  // positions with check bits at powers of two and data bits elsewhere.
  function automatic logic [CW-1:0] ecc_encode(input logic [G-1:0] data);
    logic [CW-1:0] cw;
    int unsigned j;
    cw = '0;
    j  = 0;
    for (int unsigned p = 1; p < CW; p++) begin
      if (((p & (p - 1)) != 0) && (j < G)) begin
        cw[p] = data[j];
        j++;
      end
    end
    for (int unsigned i = 0; i < K - 1; i++) begin
      for (int unsigned p = 1; p < CW; p++) begin
        if ((((p >> i) & 1) == 1) && (p != (32'd1 << i)) && ((32'd1 << i) < CW)) begin
          cw[32'd1 << i] = cw[32'd1 << i] ^ cw[p];
        end
      end
    end
    cw[0] = ^cw[CW-1:1];
    return cw;
  endfunction

  // Returns {multi, single, data}; on an uncorrectable word the raw data bits are returned.
  function automatic logic [G+1:0] ecc_decode(input logic [CW-1:0] cw_in);
    logic [CW-1:0] cw;
    logic [G-1:0]  data;
    logic          single;
    logic          multi;
    int unsigned   synd;
    int unsigned   j;
    cw     = cw_in;
    synd   = 0;
    single = 1'b0;
    multi  = 1'b0;
    for (int unsigned i = 0; i < K - 1; i++) begin
      for (int unsigned p = 1; p < CW; p++) begin
        if ((((p >> i) & 1) == 1) && cw_in[p]) begin
          synd = synd ^ (32'd1 << i);
        end
      end
    end
    if (^cw_in) begin
      if (synd < CW) begin
        cw[synd] = ~cw[synd];
        single   = 1'b1;
      end else begin
        multi = 1'b1;
      end
    end else if (synd != 0) begin
      multi = 1'b1;
    end else begin
      single = 1'b0;
    end
    if (multi) begin
      cw = cw_in;
    end
    data = '0;
    j    = 0;
    for (int unsigned p = 1; p < CW; p++) begin
      if (((p & (p - 1)) != 0) && (j < G)) begin
        data[j] = cw[p];
        j++;
      end
    end
    return {multi, single, data};
  endfunction

  state_e                 state_q, state_d;
  tag_e                   tag_q [Latency];
  logic [MemW-1:0]        rd_pipe_q [Latency];
  logic [MemW-1:0]        mem_q [NumWords];
  logic [DataWidth-1:0]   rdata_q;
  logic [AddrWidth-1:0]   rmw_addr_q;
  logic [DataWidth-1:0]   rmw_wdata_q;
  logic [BeWidth-1:0]     rmw_be_q;

  tag_e                   issue_tag_s, ret_tag_s;
  wr_src_e                wr_src_s;
  logic [MemW-1:0]        ret_cw_s, mem_wdata_s;
  logic [DataWidth-1:0]   dec_data_s, merged_s, wr_data_s;
  logic [NumBanks-1:0]    dec_single_s, dec_multi_s, bank_full_s, rmw_bank_s, wr_bank_s;
  logic                   be_partial_s, rmw_load_s, mem_re_s, mem_we_s, scrub_go_s;
  logic [AddrWidth-1:0]   mem_raddr_s, mem_waddr_s, scrub_addr_s;

  assign ret_tag_s = tag_q[Latency-1];
  assign ret_cw_s  = rd_pipe_q[Latency-1];

  // Classify incoming and latched byte enables per granule.
  always_comb begin
    bank_full_s  = '0;
    rmw_bank_s   = '0;
    be_partial_s = 1'b0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      bank_full_s[b] = &be_i[b*BeG +: BeG];
      rmw_bank_s[b]  = |rmw_be_q[b*BeG +: BeG];
      be_partial_s   = be_partial_s | ((|be_i[b*BeG +: BeG]) & ~bank_full_s[b]);
    end
  end

  // Decode every granule of the returning SRAM word.
  always_comb begin
    dec_data_s   = '0;
    dec_single_s = '0;
    dec_multi_s  = '0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      {dec_multi_s[b], dec_single_s[b], dec_data_s[b*G +: G]} = ecc_decode(ret_cw_s[b*CW +: CW]);
    end
  end

  // Pick the write source, merge RMW bytes over read-back data and encode granules.
  always_comb begin
    merged_s    = dec_data_s;
    wr_data_s   = wdata_i;
    wr_bank_s   = bank_full_s;
    mem_wdata_s = '0;
    for (int unsigned y = 0; y < BeWidth; y++) begin
      if (rmw_be_q[y]) begin
        merged_s[y*ByteWidth +: ByteWidth] = rmw_wdata_q[y*ByteWidth +: ByteWidth];
      end else begin
        merged_s[y*ByteWidth +: ByteWidth] = dec_data_s[y*ByteWidth +: ByteWidth];
      end
    end
    case (wr_src_s)
      WR_RMW: begin
        wr_data_s = merged_s;
        wr_bank_s = rmw_bank_s;
      end
      WR_SCRUB: begin
        wr_data_s = dec_data_s;
        wr_bank_s = '1;
      end
      default: begin
        wr_data_s = wdata_i;
        wr_bank_s = bank_full_s;
      end
    endcase
    for (int unsigned b = 0; b < NumBanks; b++) begin
      mem_wdata_s[b*CW +: CW] = ecc_encode(wr_data_s[b*G +: G]);
    end
  end

  // Next-state, grant and SRAM command generation.
  always_comb begin
    state_d     = state_q;
    issue_tag_s = TAG_NONE;
    wr_src_s    = WR_USER;
    mem_re_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_raddr_s = addr_i;
    mem_waddr_s = addr_i;
    rmw_load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i && !we_i) begin
          mem_re_s    = 1'b1;
          issue_tag_s = TAG_USER;
        end else if (req_i && be_partial_s) begin
          mem_re_s    = 1'b1;
          issue_tag_s = TAG_RMW;
          rmw_load_s  = 1'b1;
          state_d     = RMW_WAIT;
        end else if (req_i) begin
          mem_we_s = 1'b1;
        end else if (scrub_go_s) begin
          mem_re_s    = 1'b1;
          mem_raddr_s = scrub_addr_s;
          issue_tag_s = TAG_SCRUB;
          state_d     = SCRUB_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RMW_WAIT: begin
        if (ret_tag_s == TAG_RMW) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = rmw_addr_q;
          wr_src_s    = WR_RMW;
          state_d     = IDLE;
        end else begin
          state_d = RMW_WAIT;
        end
      end
      SCRUB_WAIT: begin
        if (ret_tag_s == TAG_SCRUB) begin
          mem_we_s    = (|dec_single_s) & ~(|dec_multi_s);
          mem_waddr_s = scrub_addr_s;
          wr_src_s    = WR_SCRUB;
          state_d     = IDLE;
        end else begin
          state_d = SCRUB_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, tag pipeline, RMW latch and held read data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_be_q    <= '0;
      for (int unsigned i = 0; i < Latency; i++) begin
        tag_q[i] <= TAG_NONE;
      end
    end else begin
      state_q  <= state_d;
      tag_q[0] <= issue_tag_s;
      for (int unsigned i = 1; i < Latency; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (ret_tag_s == TAG_USER) begin
        rdata_q <= dec_data_s;
      end
      if (rmw_load_s) begin
        rmw_addr_q  <= addr_i;
        rmw_wdata_q <= wdata_i;
        rmw_be_q    <= be_i;
      end
    end
  end

  // SRAM array with per-granule write mask and a Latency-deep read data pipe; no writes in reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && mem_we_s) begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
        if (wr_bank_s[b]) begin
          mem_q[mem_waddr_s][b*CW +: CW] <= mem_wdata_s[b*CW +: CW];
        end
      end
    end
    if (mem_re_s) begin
      rd_pipe_q[0] <= mem_q[mem_raddr_s];
    end
    for (int unsigned i = 1; i < Latency; i++) begin
      rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign gnt_o          = rst_ni & (state_q == IDLE);
  assign rvalid_o       = (ret_tag_s == TAG_USER);
  assign rdata_o        = rvalid_o ? dec_data_s : rdata_q;
  assign single_error_o = rvalid_o ? dec_single_s : '0;
  assign multi_error_o  = ((ret_tag_s == TAG_USER) || (ret_tag_s == TAG_RMW)) ? dec_multi_s : '0;

`ifdef AXI_LLC_SRAM_SCRUB_EN
  localparam int unsigned CntW = $clog2(ScrubInterval);
  localparam logic [CntW-1:0] CntMax = CntW'(ScrubInterval - 1);

  logic [CntW-1:0]      idle_cnt_q;
  logic [AddrWidth-1:0] scrub_addr_q;
  logic                 scrub_done_s;

  assign scrub_done_s = (state_q == SCRUB_WAIT) && (ret_tag_s == TAG_SCRUB);
  assign scrub_go_s   = (idle_cnt_q == CntMax);
  assign scrub_addr_s = scrub_addr_q;

  // Idle counter and scrub address walker.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idle_cnt_q   <= '0;
      scrub_addr_q <= '0;
    end else begin
      if ((state_q == IDLE) && req_i) begin
        idle_cnt_q <= '0;
      end else if (scrub_done_s) begin
        idle_cnt_q <= '0;
      end else if ((state_q == IDLE) && (idle_cnt_q != CntMax)) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
      if (scrub_done_s) begin
        scrub_addr_q <= (scrub_addr_q == AddrWidth'(NumWords - 1)) ? '0 : scrub_addr_q + 1'b1;
      end
    end
  end

  assign scrub_fix_o    = scrub_done_s & (|dec_single_s) & ~(|dec_multi_s);
  assign scrub_uncorr_o = scrub_done_s & (|dec_multi_s);
`else
  assign scrub_go_s     = 1'b0;
  assign scrub_addr_s   = '0;
  assign scrub_fix_o    = 1'b0;
  assign scrub_uncorr_o = 1'b0;
`endif

endmodule
